// File: rtl/matvec_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matvec_sched_pkg
// Description : Shared types and constants for the matvec_sched scheduler
//               (FSM state encoding, int8 width, owner index width helper,
//               default watchdog limit).
// Revision    : 1.0 - initial release
// ============================================================================
package matvec_sched_pkg;

  localparam int INT8_W          = 8;
  localparam int DEFAULT_TIMEOUT = 65535;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Width of a requester index; never below one bit so the owner register exists
  function automatic int owner_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Grants the first active
//               request found scanning upward from ptr, wrapping modulo
//               NUM_REQ. The pointer register lives in the parent.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int OW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [OW-1:0]      grant_idx
);

  // Rotating priority scan: first hit from ptr upward wins
  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = OW'(idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/matvec_sched.sv
`default_nettype none
// ============================================================================
// Module      : matvec_sched
// Description : Round-robin scheduler sharing one matvec_int8 engine between
//               NUM_REQ requesters. Latches a job, starts the engine, offsets
//               the engine weight address into the global BRAM and returns
//               the result to the owning requester.
//               Optional watchdog: define MATVEC_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module matvec_sched
  import matvec_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int IN_DIM     = 128,
  parameter int OUT_DIM    = 128,
  parameter int W_ADDR_W   = 14,
  parameter int MEM_ADDR_W = 16,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*IN_DIM*INT8_W-1:0] req_vec,
  input  logic [NUM_REQ*MEM_ADDR_W-1:0]    req_base,
  output logic [NUM_REQ-1:0]               resp_valid,
  output logic [OUT_DIM*INT8_W-1:0]        resp_vec,
  output logic                             resp_err,
  output logic                             busy,
  output logic                             eng_start,
  output logic [IN_DIM*INT8_W-1:0]         eng_in_vec,
  input  logic [W_ADDR_W-1:0]              eng_weight_addr,
  input  logic                             eng_done,
  input  logic [OUT_DIM*INT8_W-1:0]        eng_out_vec,
  output logic                             eng_abort,
  output logic [MEM_ADDR_W-1:0]            mem_addr
);

  localparam int OW = owner_w(NUM_REQ);

  state_t                state, state_nxt;
  logic [OW-1:0]         ptr, owner, grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [MEM_ADDR_W-1:0] base_q;
  logic                  accept;
  logic                  expire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .OW      (OW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant is offered only while idle and out of reset, so req_ready stays 0 in reset
  assign req_ready  = (state == IDLE && rst_n) ? grant : '0;
  assign accept     = (state == IDLE) && rst_n && (|grant);
  assign busy       = (state != IDLE);
  assign eng_start  = (state == START);
  assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  // Zero-latency BRAM address: wraps modulo 2^MEM_ADDR_W
  assign mem_addr   = base_q + MEM_ADDR_W'(eng_weight_addr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; eng_done only matters in RUN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (eng_done || expire) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job capture on accept, result capture on RUN completion or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr        <= '0;
      owner      <= '0;
      base_q     <= '0;
      eng_in_vec <= '0;
      resp_vec   <= '0;
    end else begin
      if (accept) begin
        owner      <= grant_idx;
        base_q     <= req_base[grant_idx*MEM_ADDR_W +: MEM_ADDR_W];
        eng_in_vec <= req_vec[grant_idx*IN_DIM*INT8_W +: IN_DIM*INT8_W];
        ptr        <= (grant_idx == OW'(NUM_REQ-1)) ? '0 : grant_idx + OW'(1);
      end
      if (state == RUN) begin
        if (eng_done)    resp_vec <= eng_out_vec;
        else if (expire) resp_vec <= '0;
      end
    end
  end

`ifdef MATVEC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] tcnt;
  logic          err_q;

  // RUN-cycle counter, held at zero outside RUN so it is clear on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             tcnt <= '0;
    else if (state == RUN)  tcnt <= tcnt + TW'(1);
    else                    tcnt <= '0;
  end

  // Remembers that the job in flight ended by abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (expire) err_q <= 1'b1;
  end

  // A done arriving in the expiry cycle takes precedence
  assign expire    = (state == RUN) && !eng_done && (tcnt == TW'(TIMEOUT));
  assign eng_abort = expire;
  assign resp_err  = (state == RESP) && err_q;
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign eng_abort      = 1'b0;
  assign resp_err       = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matvec_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_matvec_sched
// Description : Self-checking bench for matvec_sched. Directed jobs push their
//               expected completion into a queue; a monitor pops and compares
//               on every resp_valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matvec_sched;

  localparam int NR = 4;
  localparam int ID = 128;
  localparam int OD = 128;
  localparam int WA = 14;
  localparam int MA = 16;
  localparam int TO = 16;
  localparam int VW = ID * 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*VW-1:0]  req_vec = '0;
  logic [NR*MA-1:0]  req_base = '0;
  logic [NR-1:0]     resp_valid;
  logic [OD*8-1:0]   resp_vec;
  logic              resp_err;
  logic              busy;
  logic              eng_start;
  logic [VW-1:0]     eng_in_vec;
  logic [WA-1:0]     eng_weight_addr = '0;
  logic              eng_done = 1'b0;
  logic [OD*8-1:0]   eng_out_vec = '0;
  logic              eng_abort;
  logic [MA-1:0]     mem_addr;

  matvec_sched #(
    .NUM_REQ    (NR),
    .IN_DIM     (ID),
    .OUT_DIM    (OD),
    .W_ADDR_W   (WA),
    .MEM_ADDR_W (MA),
    .TIMEOUT    (TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_vec         (req_vec),
    .req_base        (req_base),
    .resp_valid      (resp_valid),
    .resp_vec        (resp_vec),
    .resp_err        (resp_err),
    .busy            (busy),
    .eng_start       (eng_start),
    .eng_in_vec      (eng_in_vec),
    .eng_weight_addr (eng_weight_addr),
    .eng_done        (eng_done),
    .eng_out_vec     (eng_out_vec),
    .eng_abort       (eng_abort),
    .mem_addr        (mem_addr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [NR-1:0] who;
    logic [VW-1:0] vec;
    logic          err;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    int first;
    tests++;
    if (act !== exp) begin
      fails++;
      first = 0;
      for (int i = ID - 1; i >= 0; i--)
        if (act[i*8 +: 8] !== exp[i*8 +: 8]) first = i;
      $display("FAIL %s: byte %0d actual %02h required %02h", name, first,
               act[first*8 +: 8], exp[first*8 +: 8]);
    end
  endtask

  function automatic logic [VW-1:0] fill(input logic [7:0] b);
    logic [VW-1:0] v;
    for (int i = 0; i < ID; i++) v[i*8 +: 8] = b;
    return v;
  endfunction

  task automatic set_req(input int i, input logic [VW-1:0] v, input logic [MA-1:0] b);
    req_vec[i*VW +: VW]  = v;
    req_base[i*MA +: MA] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in a RUN cycle: waits, pulses done with the result, ends back in IDLE
  task automatic finish_job(input logic [NR-1:0] who, input logic [VW-1:0] res, input int lat);
    repeat (lat) tick();
    eng_done    = 1'b1;
    eng_out_vec = res;
    sbq.push_back('{who, res, 1'b0});
    tick();
    eng_done = 1'b0;
    tick();
  endtask

  // Scoreboard monitor: every completion pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && resp_valid !== '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("resp_owner", 64'(resp_valid), 64'(mon_e.who));
        chk("resp_err", 64'(resp_err), 64'(mon_e.err));
        chk_vec("resp_vec", resp_vec, mon_e.vec);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [VW-1:0] golden;
    logic [NR-1:0] oh;
    int            w;

    // ---------------- reset state
    req_valid       = 4'hF;
    eng_weight_addr = 14'h0155;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_resp_valid", 64'(resp_valid), 0);
    chk("rst_resp_err", 64'(resp_err), 0);
    chk("rst_eng_start", 64'(eng_start), 0);
    chk("rst_eng_abort", 64'(eng_abort), 0);
    chk_vec("rst_eng_in_vec", eng_in_vec, '0);
    chk_vec("rst_resp_vec", resp_vec, '0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0155);
    req_valid = '0;
    rst_n     = 1'b1;
    tick();

    // ---------------- single job, requester 1
    for (int i = 0; i < OD; i++) golden[i*8 +: 8] = 8'(i * 3 + 1);
    set_req(1, fill(8'h01), 16'h4000);
    req_valid = 4'b0010;
    #1;
    chk("single_ready", 64'(req_ready), 64'b0010);
    chk("single_busy_idle", 64'(busy), 0);
    tick();
    chk("single_start", 64'(eng_start), 1);
    chk("single_busy", 64'(busy), 1);
    chk("single_ready_start", 64'(req_ready), 0);
    chk_vec("single_in_vec", eng_in_vec, fill(8'h01));
    req_valid       = '0;
    set_req(1, fill(8'hA5), 16'h0000);
    eng_weight_addr = 14'h0123;
    #1;
    chk("single_mem_addr", 64'(mem_addr), 64'h4123);
    tick();
    chk("single_start_once", 64'(eng_start), 0);
    chk_vec("single_in_vec_held", eng_in_vec, fill(8'h01));
    finish_job(4'b0010, golden, 2);
    chk("single_idle_after", 64'(busy), 0);
    chk_vec("single_resp_held", resp_vec, golden);

    // ---------------- contention from reset: 0,1,2,3,0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) set_req(i, fill(8'(8'h10 + i)), 16'(i * 16'h1000 + 16'h0100));
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      w  = k % NR;
      oh = NR'(1) << w;
      #1;
      chk("grant_order", 64'(req_ready), 64'(oh));
      tick();
      chk("cont_start", 64'(eng_start), 1);
      chk_vec("cont_in_vec", eng_in_vec, fill(8'(8'h10 + w)));
      eng_weight_addr = 14'h0010;
      #1;
      chk("cont_mem_addr", 64'(mem_addr), 64'(w * 16'h1000 + 16'h0110));
      if (k == 4) req_valid = '0;
      tick();
      finish_job(oh, fill(8'(8'h80 + k)), k);
    end

    // ---------------- stray done in IDLE and START, base wrap
    eng_done    = 1'b1;
    eng_out_vec = fill(8'hEE);
    tick();
    chk("stray_idle_busy", 64'(busy), 0);
    chk_vec("stray_idle_nocap", resp_vec, fill(8'h84));
    eng_done = 1'b0;
    set_req(2, fill(8'h22), 16'hFFF0);
    req_valid = 4'b0100;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'b0100);
    tick();
    req_valid       = '0;
    eng_done        = 1'b1;
    eng_weight_addr = 14'h0020;
    #1;
    chk("wrap_mem_addr", 64'(mem_addr), 64'h0010);
    tick();
    eng_done = 1'b0;
    chk("stray_start_busy", 64'(busy), 1);
    chk_vec("stray_start_nocap", resp_vec, fill(8'h84));
    tick();
    chk("stray_still_run", 64'(busy), 1);
    finish_job(4'b0100, fill(8'h5A), 1);

    // ---------------- reset during RUN
    set_req(1, fill(8'h33), 16'h2000);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    tick();
    eng_weight_addr = 14'h0040;
    tick();
    rst_n = 1'b0;
    #1;
    chk("rrun_busy", 64'(busy), 0);
    chk("rrun_start", 64'(eng_start), 0);
    chk("rrun_resp_valid", 64'(resp_valid), 0);
    chk("rrun_abort", 64'(eng_abort), 0);
    chk_vec("rrun_in_vec", eng_in_vec, '0);
    chk_vec("rrun_resp_vec", resp_vec, '0);
    chk("rrun_mem_addr", 64'(mem_addr), 64'h0040);
    req_valid = 4'hF;
    #1;
    chk("rrun_ready_in_reset", 64'(req_ready), 0);
    rst_n = 1'b1;
    #1;
    chk("rrun_ptr_zero", 64'(req_ready), 64'b0001);
    req_valid = '0;
    eng_done  = 1'b1;
    repeat (3) tick();
    eng_done = 1'b0;
    chk("rrun_no_job", 64'(busy), 0);

`ifdef MATVEC_SCHED_TIMEOUT_EN
    // ---------------- watchdog with an engine that never finishes
    set_req(3, fill(8'h44), 16'h1000);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    tick();
    for (int c = 0; c < TO; c++) begin
      chk("wd_no_early_abort", 64'(eng_abort), 0);
      tick();
    end
    chk("wd_abort", 64'(eng_abort), 1);
    sbq.push_back('{4'b1000, '0, 1'b1});
    tick();
    chk("wd_abort_once", 64'(eng_abort), 0);
    tick();
    set_req(0, fill(8'h55), 16'h0000);
    req_valid = 4'b0001;
    tick();
    chk("wd_next_start", 64'(eng_start), 1);
    req_valid = '0;
    tick();
    finish_job(4'b0001, fill(8'h66), 0);
`endif

    repeat (3) tick();
    chk("scoreboard_drained", 64'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
